rggen_apb_csr_bank: RTL and testbench
=====================================

Name: rggen_apb_csr_bank

Overview:
Parametrised APB slave register bank holding TOTAL_REGISTERS word-aligned registers. Each bit is configured per register as RW, RO or W1C (write-1-to-clear, hardware-set). It also provides programmable wait states, per-byte write strobes, error response on unmapped addresses, and an interrupt output ORed from enabled W1C status bits. It sits between the APB fabric and block logic, replacing per-design hand-instantiated register/bit-field trees.

Parameters:
ADDRESS_WIDTH, 7, APB local address width in bytes; must be at least clog2(TOTAL_REGISTERS)+2.
DATA_WIDTH, 32, register and bus width; must be a multiple of 8.
TOTAL_REGISTERS, 4, number of registers, at byte offsets 4*k.
WAIT_CYCLES, 0, extra access cycles inserted before pready (0..15).
RW_MASK, all-ones, packed [TOTAL_REGISTERS][DATA_WIDTH]; 1 marks an RW bit.
W1C_MASK, 0, same shape; 1 marks a W1C bit. Bits with neither mask set are RO. RW_MASK & W1C_MASK must be 0 (elaboration assertion).
INITIAL_VALUE, 0, same shape; reset value of RW and W1C bits.
IRQ_MASK, 0, same shape; W1C bits that contribute to o_irq.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  APB write
paddr  input  ADDRESS_WIDTH  APB byte address
pwdata  input  DATA_WIDTH  write data
pstrb  input  DATA_WIDTH/8  byte write strobes
pready  output  1  transfer complete
prdata  output  DATA_WIDTH  read data
pslverr  output  1  error response
o_value  output  TOTAL_REGISTERS*DATA_WIDTH  current RW/W1C bit values; RO positions read 0
i_value  input  TOTAL_REGISTERS*DATA_WIDTH  RO bit sources
i_set  input  TOTAL_REGISTERS*DATA_WIDTH  one-cycle set pulses for W1C bits; ignored elsewhere
o_irq  output  1  registered interrupt

Behaviour:
- One clock (clk). Synchronous active-high reset (rst). All state updates on rising clk.
- Reset values: FSM IDLE, wait counter 0, RW/W1C bits = INITIAL_VALUE, o_irq 0. pready, pslverr and prdata are driven low because the FSM is IDLE.
- FSM states:
  - IDLE: on psel & !penable (setup phase), go to ACCESS and load cnt = WAIT_CYCLES.
  - ACCESS: if psel & penable and cnt != 0, decrement cnt.
  - ACCESS: if psel & penable and cnt == 0, complete the transfer and return to IDLE.
  - ACCESS: if psel drops, the transfer is abandoned; return to IDLE with no side effects.
- pready = (state==ACCESS) & psel & penable & (cnt==0), combinational. With WAIT_CYCLES=0 the first access cycle completes (standard zero-wait APB). Transfer latency from setup is WAIT_CYCLES+2 cycles.
- Decode: index = paddr[ADDRESS_WIDTH-1:2]; paddr[1:0] are ignored. index >= TOTAL_REGISTERS is unmapped.
- Unmapped access: pslverr=1 and prdata=0 in the completion cycle; no state change.
- Mapped access: pslverr=0.
- prdata is driven only in the completion cycle of a mapped read, else 0. Read value per bit: RW/W1C bits from storage, RO bits from i_value (sampled combinationally).
- Write commits at the completing edge. For each byte with pstrb set:
  - RW bits take pwdata.
  - W1C bits are cleared where pwdata=1.
  - RO bits are unaffected.
- Bytes with pstrb clear are untouched. pstrb=0 is a legal no-op write.
- W1C set: i_set=1 sets the bit on any cycle. Set and write-1-clear on the same edge: set wins, bit stays 1.
- Reads have no side effects (no read-clear).
- o_irq <= |(W1C storage & IRQ_MASK), registered; asserts one cycle after a status bit becomes 1.
- rst asserted mid-transfer: FSM returns to IDLE, the pending write is dropped, pready stays 0 during reset.
- A setup phase seen while in ACCESS (protocol violation) is ignored until completion.

Decomposition:
- Package rggen_apb_csr_pkg:
  - state_e enum {IDLE, ACCESS}
  - WAIT_COUNT_WIDTH = 4
  - function byte_mask_expand(pstrb) -> DATA_WIDTH bit mask
- Sub-module rggen_apb_csr_reg: one register with per-bit RW/W1C/RO update logic and read mux. It is instantiated TOTAL_REGISTERS times in a generate loop. The top holds the FSM, decode, read mux and irq register.

Test Plan:
- Reset, then read reg0 with INITIAL_VALUE[0]=32'h0000_00A5, WAIT_CYCLES=0 -> pready in the first access cycle, prdata=32'h0000_00A5, pslverr=0.
- Write 32'hDEAD_BEEF to reg1 (all RW) with pstrb=4'b0101, then read -> prdata=32'h00AD_00EF and o_value slice 1 matches.
- WAIT_CYCLES=3, write reg0 -> pready low for 3 access cycles and high on the 4th; o_value changes only after the 4th edge.
- Read paddr=7'h10 with TOTAL_REGISTERS=4 -> pslverr=1, prdata=0, no register changes.
- reg2 bit0 W1C with IRQ_MASK bit0 set: pulse i_set bit0 -> o_irq=1 one cycle later. Write 1 with a simultaneous i_set -> bit stays 1. Write 1 alone -> bit 0 and o_irq 0 next cycle.
- Assert rst during the ACCESS wait of a write to reg0 -> reg0 returns to INITIAL_VALUE, FSM IDLE, no pready, and the next transfer completes normally.

Source files
------------

// File: rtl/rggen_apb_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rggen_apb_csr_pkg
// Description : Shared types, constants and helpers for the APB CSR bank.
// Revision    : 1.0 - initial release
// ============================================================================
package rggen_apb_csr_pkg;

    // Bus-side transfer state; explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Width of the wait-state down-counter (supports 0..15 extra cycles).
    localparam int WAIT_COUNT_WIDTH = 4;

    // Widest bus the byte-mask helper supports; callers truncate the result.
    localparam int c_max_data_width = 1024;
    localparam int c_max_strb_width = c_max_data_width / 8;

    // Expand one strobe bit per byte into a per-bit write mask.
    function automatic logic [c_max_data_width-1:0] byte_mask_expand(
        input logic [c_max_strb_width-1:0] strb
    );
        logic [c_max_data_width-1:0] mask;
        mask = '0;
        for (int b = 0; b < c_max_strb_width; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_apb_csr_reg.sv
`default_nettype none
// ============================================================================
// Module      : rggen_apb_csr_reg
// Description : One CSR word with per-bit RW / W1C / RO behaviour and the
//               read-value merge of stored bits with live RO inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_apb_csr_reg #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] RW_MASK       = '1,
    parameter logic [DATA_WIDTH-1:0] W1C_MASK      = '0,
    parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_bit_mask,
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic [DATA_WIDTH-1:0] i_set,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // Only RW and W1C positions hold state; RO positions stay 0 in storage.
    localparam logic [DATA_WIDTH-1:0] c_store_mask  = RW_MASK | W1C_MASK;
    localparam logic [DATA_WIDTH-1:0] c_reset_value = INITIAL_VALUE & c_store_mask;

    logic [DATA_WIDTH-1:0] r_value;
    logic [DATA_WIDTH-1:0] w_write_bits;
    logic [DATA_WIDTH-1:0] w_rw_update;
    logic [DATA_WIDTH-1:0] w_w1c_clear;
    logic [DATA_WIDTH-1:0] w_w1c_set;
    logic [DATA_WIDTH-1:0] w_next;

    assign w_write_bits = {DATA_WIDTH{i_write}} & i_bit_mask;
    assign w_rw_update  = w_write_bits & RW_MASK;
    assign w_w1c_clear  = w_write_bits & W1C_MASK & i_wdata;
    assign w_w1c_set    = i_set & W1C_MASK;

    // Hardware set is ORed in last so it wins over a same-edge write-1 clear.
    assign w_next = ((r_value & ~w_rw_update & ~w_w1c_clear)
                   | (i_wdata & w_rw_update)
                   | w_w1c_set) & c_store_mask;

    // Storage update: reset to the initial value, else apply writes and sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= c_reset_value;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;
    assign o_rdata = (r_value & c_store_mask) | (i_value & ~c_store_mask);

endmodule
`default_nettype wire

// File: rtl/rggen_apb_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : rggen_apb_csr_bank
// Description : APB slave register bank: transfer FSM with programmable wait
//               states, word decode, byte strobes, error on unmapped
//               addresses and a registered interrupt from W1C status bits.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_apb_csr_bank
    import rggen_apb_csr_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 7,
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 4,
    parameter int WAIT_CYCLES     = 0,
    parameter logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0] RW_MASK       = '1,
    parameter logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0] W1C_MASK      = '0,
    parameter logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0] INITIAL_VALUE = '0,
    parameter logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0] IRQ_MASK      = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  psel,
    input  logic                                  penable,
    input  logic                                  pwrite,
    input  logic [ADDRESS_WIDTH-1:0]              paddr,
    input  logic [DATA_WIDTH-1:0]                 pwdata,
    input  logic [DATA_WIDTH/8-1:0]               pstrb,
    output logic                                  pready,
    output logic [DATA_WIDTH-1:0]                 prdata,
    output logic                                  pslverr,
    output logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] o_value,
    input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_value,
    input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_set,
    output logic                                  o_irq
);

    localparam int c_strb_width  = DATA_WIDTH / 8;
    localparam int c_index_width = ADDRESS_WIDTH - 2;
    localparam logic [WAIT_COUNT_WIDTH-1:0] c_wait_load = WAIT_COUNT_WIDTH'(WAIT_CYCLES);
    localparam logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] c_irq_bits = IRQ_MASK & W1C_MASK;

    // Reject illegal configurations at elaboration time.
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > c_max_data_width) begin : g_check_data_width
        $error("rggen_apb_csr_bank: DATA_WIDTH must be a multiple of 8 and <= %0d", c_max_data_width);
    end
    if (ADDRESS_WIDTH < $clog2(TOTAL_REGISTERS) + 2) begin : g_check_addr_width
        $error("rggen_apb_csr_bank: ADDRESS_WIDTH too small for TOTAL_REGISTERS");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_check_wait
        $error("rggen_apb_csr_bank: WAIT_CYCLES must be 0..15");
    end
    if ((RW_MASK & W1C_MASK) != '0) begin : g_check_mask_overlap
        $error("rggen_apb_csr_bank: RW_MASK and W1C_MASK overlap");
    end

    state_e                           r_state;
    state_e                           w_state_next;
    logic [WAIT_COUNT_WIDTH-1:0]      r_cnt;
    logic [WAIT_COUNT_WIDTH-1:0]      w_cnt_next;
    logic                             r_irq;

    logic                             w_setup;
    logic                             w_access;
    logic                             w_pready;
    logic [c_index_width-1:0]         w_index;
    logic                             w_mapped;
    logic                             w_write_commit;
    logic [TOTAL_REGISTERS-1:0]       w_reg_write;
    logic [c_max_strb_width-1:0]      w_strb_ext;
    logic [DATA_WIDTH-1:0]            w_byte_mask;
    logic [DATA_WIDTH-1:0]            w_reg_rdata [TOTAL_REGISTERS];
    logic [DATA_WIDTH-1:0]            w_read_sel;
    logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] w_value;
    logic                             w_addr_lsb_unused;

    assign w_setup  = psel & ~penable;
    assign w_access = psel & penable;

    // Byte offset bits inside a word carry no meaning for this bank.
    assign w_addr_lsb_unused = ^paddr[1:0];
    assign w_index           = paddr[ADDRESS_WIDTH-1:2];
    assign w_mapped          = int'(w_index) < TOTAL_REGISTERS;

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: setup loads the wait count, access counts it down.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_state_next = ACCESS;
                    w_cnt_next   = c_wait_load;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    w_state_next = IDLE;
                end else if (penable) begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Held low during reset so a completion can never coincide with reset.
    assign w_pready       = ~rst & (r_state == ACCESS) & w_access & (r_cnt == '0);
    assign w_write_commit = w_pready & pwrite & w_mapped;

    // Zero-extend the strobes into the helper's fixed-width input.
    always_comb begin
        w_strb_ext                   = '0;
        w_strb_ext[c_strb_width-1:0] = pstrb;
    end
    assign w_byte_mask = DATA_WIDTH'(byte_mask_expand(w_strb_ext));

    for (genvar k = 0; k < TOTAL_REGISTERS; k++) begin : g_reg
        assign w_reg_write[k] = w_write_commit & (w_index == c_index_width'(k));

        rggen_apb_csr_reg #(
            .DATA_WIDTH    (DATA_WIDTH),
            .RW_MASK       (RW_MASK[k]),
            .W1C_MASK      (W1C_MASK[k]),
            .INITIAL_VALUE (INITIAL_VALUE[k])
        ) u_reg (
            .clk        (clk),
            .rst        (rst),
            .i_write    (w_reg_write[k]),
            .i_wdata    (pwdata),
            .i_bit_mask (w_byte_mask),
            .i_value    (i_value[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_set      (i_set[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_value    (w_value[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_rdata    (w_reg_rdata[k])
        );
    end

    // Read mux over mapped registers.
    always_comb begin
        w_read_sel = '0;
        for (int k = 0; k < TOTAL_REGISTERS; k++) begin
            if (int'(w_index) == k) begin
                w_read_sel = w_reg_rdata[k];
            end
        end
    end

    // Interrupt is a registered OR of enabled W1C status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_value & c_irq_bits);
        end
    end

    assign pready  = w_pready;
    assign pslverr = w_pready & ~w_mapped;
    assign prdata  = (w_pready & ~pwrite & w_mapped) ? w_read_sel : '0;
    assign o_value = w_value;
    assign o_irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_rggen_apb_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rggen_apb_csr_bank
// Description : Scoreboard bench for the APB CSR bank; one zero-wait
//               instance and one three-wait-state instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rggen_apb_csr_bank;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NR = 4;

    // reg0/reg1 all RW, reg2 = bits[7:4] RW + bit0 W1C (irq), reg3 all RO.
    localparam logic [NR-1:0][DW-1:0] RW_M   = {32'h0000_0000, 32'h0000_00F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [NR-1:0][DW-1:0] W1C_M  = {32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    localparam logic [NR-1:0][DW-1:0] INIT_V = {32'h0000_0000, 32'h0000_0030, 32'h0000_0000, 32'h0000_00A5};
    localparam logic [NR-1:0][DW-1:0] IRQ_M  = {32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rst_w;
    logic              psel_v    [2];
    logic              penable_v [2];
    logic              pwrite_v  [2];
    logic [AW-1:0]     paddr_v   [2];
    logic [DW-1:0]     pwdata_v  [2];
    logic [DW/8-1:0]   pstrb_v   [2];
    logic              pready_v  [2];
    logic [DW-1:0]     prdata_v  [2];
    logic              pslverr_v [2];
    logic [NR*DW-1:0]  ovalue_v  [2];
    logic [NR*DW-1:0]  iset_v    [2];
    logic              irq_v     [2];
    logic [NR*DW-1:0]  ivalue = {32'h1234_5678, 32'hABCD_00FF, 32'h5A5A_5A5A, 32'hFFFF_FFFF};

    exp_t              q0[$];
    exp_t              q1[$];
    int                errors = 0;
    int                checks = 0;
    logic [NR*DW-1:0]  ov_at_ready;

    always #5 clk = ~clk;

    rggen_apb_csr_bank #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .WAIT_CYCLES(0),
        .RW_MASK(RW_M), .W1C_MASK(W1C_M), .INITIAL_VALUE(INIT_V), .IRQ_MASK(IRQ_M)
    ) dut0 (
        .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable_v[0]), .pwrite(pwrite_v[0]),
        .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .pstrb(pstrb_v[0]), .pready(pready_v[0]),
        .prdata(prdata_v[0]), .pslverr(pslverr_v[0]), .o_value(ovalue_v[0]), .i_value(ivalue),
        .i_set(iset_v[0]), .o_irq(irq_v[0])
    );

    rggen_apb_csr_bank #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .WAIT_CYCLES(3),
        .RW_MASK(RW_M), .W1C_MASK(W1C_M), .INITIAL_VALUE(INIT_V), .IRQ_MASK(IRQ_M)
    ) dut3 (
        .clk(clk), .rst(rst_w), .psel(psel_v[1]), .penable(penable_v[1]), .pwrite(pwrite_v[1]),
        .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .pstrb(pstrb_v[1]), .pready(pready_v[1]),
        .prdata(prdata_v[1]), .pslverr(pslverr_v[1]), .o_value(ovalue_v[1]), .i_value(ivalue),
        .i_set(iset_v[1]), .o_irq(irq_v[1])
    );

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected response whenever an instance completes.
    task automatic mon(input int w);
        exp_t e;
        logic empty;
        checks++;
        empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            errors++;
            $display("FAIL unexpected_pready dut%0d: got pready=1 expected no pending transfer", w);
        end else begin
            if (w == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (w == 1) ov_at_ready = ovalue_v[1];
            if (pslverr_v[w] !== e.err || prdata_v[w] !== e.rdata) begin
                errors++;
                $display("FAIL response dut%0d: got pslverr=%0b prdata=%h expected pslverr=%0b prdata=%h",
                         w, pslverr_v[w], prdata_v[w], e.err, e.rdata);
            end
        end
    endtask

    always @(negedge clk) begin
        if (pready_v[0] === 1'b1) mon(0);
        if (pready_v[1] === 1'b1) mon(1);
    end

    // Drive one APB transfer; the expected response goes to the scoreboard.
    task automatic xfer(input int w, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW/8-1:0] strb, input logic exp_err, input logic [DW-1:0] exp_rd,
                        input int exp_cycles, input logic [NR*DW-1:0] set);
        exp_t e;
        int   n;
        logic done;
        e.err   = exp_err;
        e.rdata = exp_rd;
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        psel_v[w] = 1'b1; penable_v[w] = 1'b0; pwrite_v[w] = wr;
        paddr_v[w] = addr; pwdata_v[w] = data; pstrb_v[w] = strb;
        @(posedge clk); #1;
        penable_v[w] = 1'b1;
        iset_v[w]    = set;
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (pready_v[w] === 1'b1) done = 1'b1;
            else @(posedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout dut%0d addr=%h: got no pready expected pready within 20 cycles", w, addr);
        end else if (n != exp_cycles) begin
            errors++;
            $display("FAIL access_cycles dut%0d addr=%h: got %0d expected %0d", w, addr, n, exp_cycles);
        end
        @(posedge clk); #1;
        psel_v[w] = 1'b0; penable_v[w] = 1'b0; iset_v[w] = '0;
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel_v[i] = 1'b0; penable_v[i] = 1'b0; pwrite_v[i] = 1'b0; paddr_v[i] = '0;
            pwdata_v[i] = '0; pstrb_v[i] = '0; iset_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs0", {pready_v[0], pslverr_v[0], irq_v[0], prdata_v[0]}, '0);
        check("reset_outputs3", {pready_v[1], pslverr_v[1], irq_v[1], prdata_v[1]}, '0);
        check("reset_value0", ovalue_v[0], {32'h0, 32'h30, 32'h0, 32'hA5});
        check("reset_value3", ovalue_v[1], {32'h0, 32'h30, 32'h0, 32'hA5});
        @(posedge clk); #1;
        rst = 1'b0; rst_w = 1'b0;

        // Zero-wait read of the initial value.
        xfer(0, 1'b0, 7'h00, '0, 4'h0, 1'b0, 32'h0000_00A5, 1, '0);
        // Partial strobe write and read-back.
        xfer(0, 1'b1, 7'h04, 32'hDEAD_BEEF, 4'b0101, 1'b0, 32'h0, 1, '0);
        xfer(0, 1'b0, 7'h04, '0, 4'h0, 1'b0, 32'h00AD_00EF, 1, '0);
        check("strobe_o_value", {96'h0, ovalue_v[0][63:32]}, {96'h0, 32'h00AD_00EF});
        // pstrb=0 write is a no-op.
        xfer(0, 1'b1, 7'h04, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, 1, '0);
        xfer(0, 1'b0, 7'h04, '0, 4'h0, 1'b0, 32'h00AD_00EF, 1, '0);
        // Unmapped read and write.
        xfer(0, 1'b0, 7'h10, '0, 4'h0, 1'b1, 32'h0, 1, '0);
        xfer(0, 1'b1, 7'h14, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1, '0);
        check("unmapped_no_change", ovalue_v[0], {32'h0, 32'h30, 32'h00AD_00EF, 32'hA5});
        // RO register reads live input, ignores writes.
        xfer(0, 1'b0, 7'h0C, '0, 4'h0, 1'b0, 32'h1234_5678, 1, '0);
        xfer(0, 1'b1, 7'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1, '0);
        xfer(0, 1'b0, 7'h0C, '0, 4'h0, 1'b0, 32'h1234_5678, 1, '0);
        // Mixed register, low address bits ignored.
        xfer(0, 1'b0, 7'h0B, '0, 4'h0, 1'b0, 32'hABCD_003E, 1, '0);

        // W1C hardware set and interrupt latency.
        @(posedge clk); #1;
        iset_v[0] = 128'h1 << 64;
        @(posedge clk); #1;
        iset_v[0] = '0;
        @(negedge clk);
        check("w1c_set_bit", {127'h0, ovalue_v[0][64]}, 128'h1);
        check("irq_not_yet", {127'h0, irq_v[0]}, 128'h0);
        @(negedge clk);
        check("irq_asserted", {127'h0, irq_v[0]}, 128'h1);
        // Write-1 clear with simultaneous set: set wins.
        xfer(0, 1'b1, 7'h08, 32'h0000_0031, 4'b0001, 1'b0, 32'h0, 1, 128'h1 << 64);
        check("set_wins_bit", {127'h0, ovalue_v[0][64]}, 128'h1);
        check("set_wins_irq", {127'h0, irq_v[0]}, 128'h1);
        // Write-1 clear alone.
        xfer(0, 1'b1, 7'h08, 32'h0000_0031, 4'b0001, 1'b0, 32'h0, 1, '0);
        check("w1c_cleared", {127'h0, ovalue_v[0][64]}, 128'h0);
        check("irq_still_registered", {127'h0, irq_v[0]}, 128'h1);
        @(posedge clk); #1;
        check("irq_deasserted", {127'h0, irq_v[0]}, 128'h0);
        xfer(0, 1'b0, 7'h08, '0, 4'h0, 1'b0, 32'hABCD_003E, 1, '0);

        // Three wait states: completion on the 4th access cycle.
        xfer(1, 1'b1, 7'h00, 32'h1111_2222, 4'hF, 1'b0, 32'h0, 4, '0);
        check("wait_value_before_edge", {96'h0, ov_at_ready[31:0]}, {96'h0, 32'h0000_00A5});
        check("wait_value_after_edge", {96'h0, ovalue_v[1][31:0]}, {96'h0, 32'h1111_2222});
        xfer(1, 1'b0, 7'h00, '0, 4'h0, 1'b0, 32'h1111_2222, 4, '0);

        // Reset arriving in the would-be completion cycle of a write.
        @(posedge clk); #1;
        psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
        paddr_v[1] = 7'h00; pwdata_v[1] = 32'h5555_AAAA; pstrb_v[1] = 4'hF;
        @(posedge clk); #1;
        penable_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_w = 1'b1;
        @(negedge clk);
        check("pready_low_in_reset", {127'h0, pready_v[1]}, 128'h0);
        @(posedge clk); #1;
        rst_w = 1'b0; psel_v[1] = 1'b0; penable_v[1] = 1'b0;
        @(negedge clk);
        check("reset_mid_value", ovalue_v[1], {32'h0, 32'h30, 32'h0, 32'hA5});
        xfer(1, 1'b0, 7'h00, '0, 4'h0, 1'b0, 32'h0000_00A5, 4, '0);

        repeat (2) @(posedge clk);
        check("q0_drained", 128'(q0.size()), 128'h0);
        check("q1_drained", 128'(q1.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
